// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master: FSM state encoding, SPI mode constants
// ({cpol, cpha}) and a helper that sizes the chip-select index.
package spi_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} spi_state_e;

   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   // A single-slave build still carries a 1-bit index.
   function automatic int unsigned cs_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_master_gen2_if.sv
// Host-side request/response bus of spi_master_gen2. The host drives the master modport and
// the SPI master takes the slave modport.
interface spi_master_gen2_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NUM_CS = 4,
   parameter int unsigned DIV_W  = 8
) ();
   import spi_pkg::*;

   localparam int unsigned CS_W = cs_width(NUM_CS);

   logic              start;
   logic [DATA_W-1:0] tx_data;
   logic [CS_W-1:0]   cs_sel;
   logic              cpol;
   logic              cpha;
   logic [DIV_W-1:0]  clk_div;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              busy;

   modport master (
      output start, tx_data, cs_sel, cpol, cpha, clk_div,
      input  rx_data, rx_valid, busy
   );

   modport slave (
      input  start, tx_data, cs_sel, cpol, cpha, clk_div,
      output rx_data, rx_valid, busy
   );

endinterface

// File: rtl/spi_sclk_gen.sv
// Clock divider for the SPI master: a tick closes every (div+1)-cycle period while enabled,
// and within SHIFT the ticks alternate between leading and trailing sclk edge strobes.
module spi_sclk_gen #(
   parameter int unsigned DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             shift,
   input  logic [DIV_W-1:0] div,
   output logic             tick,
   output logic             lead,
   output logic             trail
);

   // One spare bit keeps the counter from wrapping when div is all ones.
   logic [DIV_W:0] cnt_q, cnt_d;
   logic           phase_q, phase_d;

   always_comb begin
      tick    = en && (cnt_q == {1'b0, div});
      cnt_d   = (!en || tick) ? '0 : cnt_q + {{DIV_W{1'b0}}, 1'b1};
      phase_d = shift ? (phase_q ^ tick) : 1'b0;
      lead    = tick && shift && !phase_q;
      trail   = tick && shift && phase_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/spi_master_gen2.sv
// Single-frame SPI master, all four modes, programmable sclk divider and one-hot-low chip
// selects. Define SPI_MASTER_LOOPBACK_EN to add a loopback input that samples mosi instead of miso.
module spi_master_gen2
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NUM_CS = 4,
   parameter int unsigned DIV_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   spi_master_gen2_if.slave  bus,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
`ifdef SPI_MASTER_LOOPBACK_EN
   input  logic              loopback,
`endif
   output logic [NUM_CS-1:0] cs_n
);

   localparam int unsigned CS_W   = cs_width(NUM_CS);
   localparam int unsigned EDGE_W = $clog2(2 * DATA_W);
   localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

   spi_state_e state_q, state_d;

   logic [DATA_W-1:0] tx_sr_q, rx_sr_q, rx_data_q;
   logic [DIV_W-1:0]  div_q;
   logic [EDGE_W-1:0] edge_q;
   logic [NUM_CS-1:0] cs_n_q;
   logic              cpha_q, sclk_q, mosi_q, rx_valid_q;
   logic              busy, accept, done, in_shift;
   logic              tick, lead, trail, sample, advance, rx_in;

   // Unmatched indices leave every select high, so out-of-range frames run unselected.
   function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
      cs_decode = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (sel == CS_W'(i)) cs_decode[i] = 1'b0;
      end
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.start) state_d = SETUP;
         SETUP:   if (tick) state_d = SHIFT;
         SHIFT:   if (tick && edge_q == LAST_EDGE) state_d = HOLD;
         HOLD:    if (tick) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state_q != IDLE);
      accept   = (state_q == IDLE) && bus.start;
      in_shift = (state_q == SHIFT);
      done     = (state_q == HOLD) && tick;
   end

   spi_sclk_gen #(
      .DIV_W (DIV_W)
   ) u_sclk_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (busy),
      .shift (in_shift),
      .div   (div_q),
      .tick  (tick),
      .lead  (lead),
      .trail (trail)
   );

   assign sample  = cpha_q ? trail : lead;
   assign advance = cpha_q ? lead : trail;

`ifdef SPI_MASTER_LOOPBACK_EN
   assign rx_in = loopback ? mosi_q : miso;
`else
   assign rx_in = miso;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_sr_q <= '0;
         mosi_q  <= 1'b0;
         cpha_q  <= 1'b0;
         div_q   <= '0;
      end else if (accept) begin
         tx_sr_q <= bus.tx_data;
         mosi_q  <= bus.tx_data[DATA_W-1];
         cpha_q  <= bus.cpha;
         div_q   <= bus.clk_div;
      end else if (advance) begin
         // cpha=1 presents the current MSB on the leading edge; cpha=0 already showed it.
         mosi_q  <= cpha_q ? tx_sr_q[DATA_W-1] : tx_sr_q[DATA_W-2];
         tx_sr_q <= tx_sr_q << 1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_q <= 1'b0;
         edge_q <= '0;
      end else if (state_q == IDLE) begin
         sclk_q <= bus.cpol;
         edge_q <= '0;
      end else if (in_shift && tick) begin
         sclk_q <= ~sclk_q;
         edge_q <= edge_q + EDGE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_sr_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         cs_n_q     <= '1;
      end else begin
         rx_valid_q <= done;
         if (accept) begin
            rx_sr_q <= '0;
            cs_n_q  <= cs_decode(bus.cs_sel);
         end else if (sample) begin
            rx_sr_q <= {rx_sr_q[DATA_W-2:0], rx_in};
         end
         if (done) begin
            rx_data_q <= rx_sr_q;
            cs_n_q    <= '1;
         end
      end
   end

   assign bus.busy     = busy;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
   assign sclk         = sclk_q;
   assign mosi         = mosi_q;
   assign cs_n         = cs_n_q;

endmodule

// File: tb/tb_spi_master_gen2.sv
// Directed bench for spi_master_gen2: a behavioural SPI slave feeds miso and captures mosi,
// and a scoreboard of expected frames is checked on every rx_valid pulse.
module tb_spi_master_gen2;
   import spi_pkg::*;

   typedef struct {
      logic [7:0] rx;
      logic [7:0] tx;
      int         lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sclk_a, mosi_a, sclk_b, mosi_b;
   logic miso_a = 1'b0;
   logic miso_b = 1'b0;
   logic [3:0] cs_n_a;
   logic [4:0] cs_n_b;
`ifdef SPI_MASTER_LOOPBACK_EN
   logic lb = 1'b0;
`endif

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int acc_cyc = 0;
   exp_t sb_q[$];
   logic [7:0] slv_q[$];

   spi_master_gen2_if #(.DATA_W(8), .NUM_CS(4), .DIV_W(8)) bus_a ();
   spi_master_gen2_if #(.DATA_W(8), .NUM_CS(5), .DIV_W(8)) bus_b ();

   spi_master_gen2 #(.DATA_W(8), .NUM_CS(4), .DIV_W(8)) dut_a (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus_a),
      .sclk     (sclk_a),
      .mosi     (mosi_a),
      .miso     (miso_a),
`ifdef SPI_MASTER_LOOPBACK_EN
      .loopback (lb),
`endif
      .cs_n     (cs_n_a)
   );

   spi_master_gen2 #(.DATA_W(8), .NUM_CS(5), .DIV_W(8)) dut_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus_b),
      .sclk     (sclk_b),
      .mosi     (mosi_b),
      .miso     (miso_b),
`ifdef SPI_MASTER_LOOPBACK_EN
      .loopback (1'b0),
`endif
      .cs_n     (cs_n_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Behavioural slave on dut_a: shifts slv_q data out on miso, captures mosi on sample edges.
   logic       s_prev_sel = 1'b0, s_prev_sclk = 1'b0, s_cpol = 1'b0, s_cpha = 1'b0;
   logic [7:0] s_sr = 8'h00, mosi_cap = 8'h00;

   always @(negedge clk) begin : slave
      logic sel, lead;
      logic [7:0] d;
      sel  = ~&cs_n_a;
      lead = (sclk_a != s_cpol);
      if (sel && !s_prev_sel) begin
         d = (slv_q.size() != 0) ? slv_q.pop_front() : 8'h00;
         s_cpol   <= bus_a.cpol;
         s_cpha   <= bus_a.cpha;
         mosi_cap <= 8'h00;
         if (!bus_a.cpha) begin
            miso_a <= d[7];
            s_sr   <= d << 1;
         end else begin
            s_sr   <= d;
         end
      end else if (sel && sclk_a != s_prev_sclk) begin
         if (s_cpha == lead) begin
            miso_a <= s_sr[7];
            s_sr   <= s_sr << 1;
         end else begin
            mosi_cap <= {mosi_cap[6:0], mosi_a};
         end
      end
      s_prev_sel  <= sel;
      s_prev_sclk <= sclk_a;
   end

   logic prev_busy = 1'b0, prev_rxv = 1'b0;

   always @(negedge clk) begin : monitor
      exp_t e;
      if (bus_a.busy && !prev_busy) acc_cyc <= cyc;
      if (bus_a.rx_valid) begin
         chk("sb_occupancy", 32'(sb_q.size() != 0), 1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("rx_data", bus_a.rx_data, e.rx);
            chk("mosi_bits", mosi_cap, e.tx);
            chk("latency", cyc - acc_cyc, e.lat);
            chk("end_cs_n", cs_n_a, 4'hF);
            chk("end_busy", bus_a.busy, 0);
         end
      end
      if (prev_rxv) chk("rx_valid_pulse", bus_a.rx_valid, 0);
      prev_busy <= bus_a.busy;
      prev_rxv  <= bus_a.rx_valid;
   end

   task automatic run_frame(input logic [7:0] tx, input logic [7:0] sd, input logic [7:0] erx,
                            input logic [1:0] mode, input logic [7:0] div, input logic [1:0] sel,
                            input logic [3:0] exp_cs);
      exp_t e;
      @(negedge clk);
      bus_a.tx_data = tx;
      bus_a.cpol    = mode[1];
      bus_a.cpha    = mode[0];
      bus_a.clk_div = div;
      bus_a.cs_sel  = sel;
      bus_a.start   = 1'b1;
      e.rx  = erx;
      e.tx  = tx;
      e.lat = 18 * (int'(div) + 1);
      sb_q.push_back(e);
      slv_q.push_back(sd);
      @(negedge clk);
      bus_a.start = 1'b0;
      chk("start_busy", bus_a.busy, 1);
      chk("start_cs_n", cs_n_a, exp_cs);
   endtask

   task automatic wait_rx(input bit use_b, input int max);
      bit seen = 1'b0;
      for (int i = 0; i < max && !seen; i++) begin
         @(negedge clk);
         if (use_b ? bus_b.rx_valid : bus_a.rx_valid) seen = 1'b1;
      end
      chk("rx_timeout", 32'(seen), 1);
   endtask

   task automatic frame_b(input logic [2:0] sel, input logic [4:0] exp_cs);
      @(negedge clk);
      bus_b.cs_sel = sel;
      bus_b.start  = 1'b1;
      @(negedge clk);
      bus_b.start = 1'b0;
      chk("b_busy", bus_b.busy, 1);
      chk("b_cs_n", cs_n_b, exp_cs);
      wait_rx(1'b1, 200);
      chk("b_end_cs_n", cs_n_b, 5'h1F);
   endtask

   initial begin
      exp_t e;
      int   hp;
      bus_a.start = 1'b0; bus_a.tx_data = '0; bus_a.cs_sel = '0;
      bus_a.cpol = 1'b1;  bus_a.cpha = 1'b0;  bus_a.clk_div = '0;
      bus_b.start = 1'b0; bus_b.tx_data = 8'h77; bus_b.cs_sel = '0;
      bus_b.cpol = 1'b0;  bus_b.cpha = 1'b0;  bus_b.clk_div = 8'd0;

      repeat (3) @(negedge clk);
      chk("rst_sclk", sclk_a, 0);
      chk("rst_mosi", mosi_a, 0);
      chk("rst_cs_n", cs_n_a, 4'hF);
      chk("rst_busy", bus_a.busy, 0);
      chk("rst_rx_valid", bus_a.rx_valid, 0);
      chk("rst_rx_data", bus_a.rx_data, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_sclk_cpol", sclk_a, 1);
      bus_a.cpol = 1'b0;

      // Mode 0, divide-by-1: 0xA5 out, 0x3C back.
      run_frame(8'hA5, 8'h3C, 8'h3C, MODE0, 8'd0, 2'd2, 4'b1011);
      wait_rx(1'b0, 100);

      // Mode 3, half-period 4: sclk idles high.
      @(negedge clk);
      bus_a.cpol = 1'b1;
      @(negedge clk);
      chk("idle_sclk_mode3", sclk_a, 1);
      run_frame(8'h81, 8'hC3, 8'hC3, MODE3, 8'd3, 2'd1, 4'b1101);
      for (int i = 0; i < 50 && sclk_a; i++) @(negedge clk);
      hp = 0;
      for (int i = 0; i < 50 && !sclk_a; i++) begin
         @(negedge clk);
         hp++;
      end
      chk("half_period", hp, 4);
      wait_rx(1'b0, 200);

      // Start during busy is ignored; start held into rx_valid gives a 1-cycle CS gap.
      run_frame(8'h3C, 8'h96, 8'h96, MODE1, 8'd1, 2'd1, 4'b1101);
      repeat (5) @(negedge clk);
      bus_a.tx_data = 8'hFF;
      bus_a.cs_sel  = 2'd3;
      bus_a.start   = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
      chk("ignored_start_cs_n", cs_n_a, 4'b1101);
      @(negedge clk);
      bus_a.tx_data = 8'h69;
      bus_a.cs_sel  = 2'd0;
      bus_a.start   = 1'b1;
      e.rx = 8'h2D; e.tx = 8'h69; e.lat = 36;
      sb_q.push_back(e);
      slv_q.push_back(8'h2D);
      wait_rx(1'b0, 200);
      chk("gap_cs_n_high", cs_n_a, 4'hF);
      @(negedge clk);
      bus_a.start = 1'b0;
      chk("b2b_cs_n_low", cs_n_a, 4'b1110);
      chk("b2b_busy", bus_a.busy, 1);
      wait_rx(1'b0, 200);

      // Chip-select boundaries on the five-slave instance.
      frame_b(3'd4, 5'b01111);
      frame_b(3'd5, 5'h1F);

      // Reset in the middle of SHIFT.
      run_frame(8'hF0, 8'h0F, 8'h0F, MODE0, 8'd2, 2'd0, 4'b1110);
      repeat (12) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_sclk", sclk_a, 0);
      chk("mid_rst_mosi", mosi_a, 0);
      chk("mid_rst_cs_n", cs_n_a, 4'hF);
      chk("mid_rst_busy", bus_a.busy, 0);
      chk("mid_rst_rx_valid", bus_a.rx_valid, 0);
      chk("mid_rst_rx_data", bus_a.rx_data, 0);
      sb_q.delete();
      slv_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(8'h33, 8'hCC, 8'hCC, MODE2, 8'd0, 2'd3, 4'b0111);
      wait_rx(1'b0, 100);

`ifdef SPI_MASTER_LOOPBACK_EN
      lb = 1'b1;
      run_frame(8'h5A, 8'hFF, 8'h5A, MODE0, 8'd1, 2'd1, 4'b1101);
      wait_rx(1'b0, 100);
      lb = 1'b0;
`endif

      repeat (5) @(negedge clk);
      chk("sb_drained", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
